// File: rtl/reg_file_pkg.sv
// Shared constants for the pipelined register file and its scoreboard.
package reg_file_pkg;

  localparam int unsigned ADDRESS_DEF = 5;
  localparam int unsigned DATA_DEF    = 32;
  localparam int unsigned PEND_W_DEF  = 2;

  // x0 is hardwired to zero and never tracked.
  localparam int unsigned ZERO_REG    = 0;

endpackage

// File: rtl/reg_file_sb_if.sv
// Read, write and issue/hazard signals between the core and reg_file_sb.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDRESS = ADDRESS_DEF,
  parameter int unsigned DATA    = DATA_DEF
) ();

  logic [ADDRESS-1:0] A1;
  logic [ADDRESS-1:0] A2;
  logic [DATA-1:0]    RD1;
  logic [DATA-1:0]    RD2;
  logic [ADDRESS-1:0] A3;
  logic [DATA-1:0]    WD3;
  logic               WE3;
  logic               ISSUE_EN;
  logic [ADDRESS-1:0] ISSUE_RD;
  logic               BUSY1;
  logic               BUSY2;
  logic               ISSUE_FULL;

  modport master (
    output A1, A2, A3, WD3, WE3, ISSUE_EN, ISSUE_RD,
    input  RD1, RD2, BUSY1, BUSY2, ISSUE_FULL
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3, ISSUE_EN, ISSUE_RD,
    output RD1, RD2, BUSY1, BUSY2, ISSUE_FULL
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters: incremented on issue, decremented on
// writeback, saturating at all-ones and never underflowing. x0 stays at 0.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDRESS = ADDRESS_DEF,
  parameter int unsigned PEND_W  = PEND_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ISSUE_EN,
  input  logic [ADDRESS-1:0] ISSUE_RD,
  input  logic               WE3,
  input  logic [ADDRESS-1:0] A3,
  input  logic [ADDRESS-1:0] A1,
  input  logic [ADDRESS-1:0] A2,
  output logic               cnt_is_one1,
  output logic               cnt_is_one2,
  output logic               busy1,
  output logic               busy2,
  output logic               ISSUE_FULL
);

  localparam int unsigned Depth = 2 ** ADDRESS;

  logic [PEND_W-1:0]  cnt [Depth];
  logic [Depth-1:1]   inc;
  logic [Depth-1:1]   dec;

  // Saturation lookup; an issue to x0 never reports full.
  always_comb begin
    ISSUE_FULL = (ISSUE_RD != ADDRESS'(ZERO_REG)) && (cnt[ISSUE_RD] == '1);
  end

  // Per-entry increment/decrement requests.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 1; i < Depth; i++) begin
      inc[i] = ISSUE_EN && (ISSUE_RD == ADDRESS'(i)) && !ISSUE_FULL;
      dec[i] = WE3 && (A3 == ADDRESS'(i)) && (cnt[i] != '0);
    end
  end

  // Counter array; simultaneous inc and dec cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) cnt[i] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int i = 1; i < Depth; i++) begin
        if (inc[i] && !dec[i]) begin
          cnt[i] <= cnt[i] + PEND_W'(1);
        end else if (dec[i] && !inc[i]) begin
          cnt[i] <= cnt[i] - PEND_W'(1);
        end
      end
    end
  end

  // Raw busy and last-pending flags for the read ports.
  always_comb begin
    busy1       = (cnt[A1] != '0);
    busy2       = (cnt[A2] != '0);
    cnt_is_one1 = (cnt[A1] == PEND_W'(1));
    cnt_is_one2 = (cnt[A2] == PEND_W'(1));
  end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with x0 hardwired to zero and a pending-
// write scoreboard for decode hazard stalls.
// Build option: REGFILE_BYPASS_EN forwards WD3 to matching read ports and
// clears BUSY during the retiring write cycle.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDRESS = ADDRESS_DEF,
  parameter int unsigned DATA    = DATA_DEF,
  parameter int unsigned PEND_W  = PEND_W_DEF
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);

  localparam int unsigned Depth = 2 ** ADDRESS;

  logic [DATA-1:0] regs [Depth-1:1];
  logic [DATA-1:0] rd1_stored;
  logic [DATA-1:0] rd2_stored;
  logic            busy1;
  logic            busy2;
  logic            cnt_is_one1;
  logic            cnt_is_one2;
  logic            full;

  reg_scoreboard #(
    .ADDRESS (ADDRESS),
    .PEND_W  (PEND_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .ISSUE_EN    (bus.ISSUE_EN),
    .ISSUE_RD    (bus.ISSUE_RD),
    .WE3         (bus.WE3),
    .A3          (bus.A3),
    .A1          (bus.A1),
    .A2          (bus.A2),
    .cnt_is_one1 (cnt_is_one1),
    .cnt_is_one2 (cnt_is_one2),
    .busy1       (busy1),
    .busy2       (busy2),
    .ISSUE_FULL  (full)
  );

  // Register storage; writes to x0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < Depth; i++) regs[i] <= '0;
    end else if (bus.WE3 && (bus.A3 != ADDRESS'(ZERO_REG))) begin
      regs[bus.A3] <= bus.WD3;
    end
  end

  // Stored read values with x0 reading zero.
  always_comb begin
    rd1_stored = (bus.A1 == ADDRESS'(ZERO_REG)) ? '0 : regs[bus.A1];
    rd2_stored = (bus.A2 == ADDRESS'(ZERO_REG)) ? '0 : regs[bus.A2];
  end

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;

  // Same-cycle forwarding of writeback data and retire-aware busy.
  always_comb begin
    hit1     = bus.WE3 && (bus.A3 == bus.A1) && (bus.A1 != ADDRESS'(ZERO_REG));
    hit2     = bus.WE3 && (bus.A3 == bus.A2) && (bus.A2 != ADDRESS'(ZERO_REG));
    bus.RD1  = hit1 ? bus.WD3 : rd1_stored;
    bus.RD2  = hit2 ? bus.WD3 : rd2_stored;
    bus.BUSY1 = busy1 && !(hit1 && cnt_is_one1);
    bus.BUSY2 = busy2 && !(hit2 && cnt_is_one2);
  end
`else
  logic unused_cnt_is_one;
  assign unused_cnt_is_one = cnt_is_one1 ^ cnt_is_one2;

  // No forwarding: reads and busy reflect state before the edge.
  always_comb begin
    bus.RD1   = rd1_stored;
    bus.RD2   = rd2_stored;
    bus.BUSY1 = busy1;
    bus.BUSY2 = busy2;
  end
`endif

  // Saturation flag passes straight through.
  always_comb begin
    bus.ISSUE_FULL = full;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb; expected values go through a queue and are
// popped at each sample point.
module tb_reg_file_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] exp_q [$];

  reg_file_sb_if #(.ADDRESS(5), .DATA(32)) bus ();

  reg_file_sb #(.ADDRESS(5), .DATA(32), .PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.WD3 = '0; bus.WE3 = 1'b0;
    bus.ISSUE_EN = 1'b0; bus.ISSUE_RD = '0;
  endtask

  // Advance to the next falling edge and clear all stimulus.
  task automatic nx();
    @(negedge clk);
    idle();
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst = 1'b1;
    #1;
    push(32'h0); chk("reset_rd1", bus.RD1);
    push(32'h0); chk("reset_busy1", {31'b0, bus.BUSY1});
    push(32'h0); chk("reset_full", {31'b0, bus.ISSUE_FULL});
    nx();
    rst = 1'b0;

    // Reset mid-run: write and issue reg5, then reset between edges.
    nx();
    bus.WE3 = 1'b1; bus.A3 = 5'd5; bus.WD3 = 32'hDEADBEEF;
    bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd5;
    nx();
    bus.A1 = 5'd5; bus.ISSUE_RD = 5'd5;
    #1;
    push(32'hDEADBEEF); chk("r5_written", bus.RD1);
    push(32'h1); chk("r5_busy", {31'b0, bus.BUSY1});
    #2;
    rst = 1'b1;
    #1;
    push(32'h0); chk("midrst_rd1", bus.RD1);
    push(32'h0); chk("midrst_busy1", {31'b0, bus.BUSY1});
    push(32'h0); chk("midrst_full", {31'b0, bus.ISSUE_FULL});
    nx();
    rst = 1'b0;

    // x0: write and issue to register 0 are ignored.
    nx();
    bus.WE3 = 1'b1; bus.A3 = 5'd0; bus.WD3 = 32'hFFFFFFFF;
    bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd0;
    #1;
    push(32'h0); chk("x0_full", {31'b0, bus.ISSUE_FULL});
    nx();
    bus.A1 = 5'd0;
    #1;
    push(32'h0); chk("x0_rd1", bus.RD1);
    push(32'h0); chk("x0_busy1", {31'b0, bus.BUSY1});

    // Saturation on reg7: three issues fill, fourth dropped.
    for (int k = 0; k < 3; k++) begin
      nx();
      bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd7;
      #1;
      push(32'h0); chk($sformatf("r7_notfull_%0d", k), {31'b0, bus.ISSUE_FULL});
    end
    nx();
    bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd7;
    #1;
    push(32'h1); chk("r7_full", {31'b0, bus.ISSUE_FULL});
    for (int k = 0; k < 3; k++) begin
      nx();
      bus.WE3 = 1'b1; bus.A3 = 5'd7; bus.WD3 = 32'h7000_0000 + k; bus.A2 = 5'd7;
      #1;
      push((k == 2 && Bypass) ? 32'h0 : 32'h1);
      chk($sformatf("r7_busy_wr%0d", k), {31'b0, bus.BUSY2});
    end
    nx();
    bus.A2 = 5'd7;
    #1;
    push(32'h0); chk("r7_busy_done", {31'b0, bus.BUSY2});
    push(32'h7000_0002); chk("r7_data", bus.RD2);

    // Simultaneous issue and retire on reg3 with one pending.
    nx();
    bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd3;
    nx();
    bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd3;
    bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'h0000A5A5; bus.A1 = 5'd3;
    #1;
    push(Bypass ? 32'h0 : 32'h1); chk("r3_busy_same", {31'b0, bus.BUSY1});
    nx();
    bus.A1 = 5'd3;
    #1;
    push(32'h1); chk("r3_busy_after", {31'b0, bus.BUSY1});
    push(32'h0000A5A5); chk("r3_data", bus.RD1);
    nx();
    bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'h0000A5A6;
    nx();
    bus.A1 = 5'd3;
    #1;
    push(32'h0); chk("r3_busy_clear", {31'b0, bus.BUSY1});

    // Bypass window on reg4 with one pending write.
    nx();
    bus.WE3 = 1'b1; bus.A3 = 5'd4; bus.WD3 = 32'h0BAD0BAD;
    bus.ISSUE_EN = 1'b1; bus.ISSUE_RD = 5'd4;
    nx();
    bus.WE3 = 1'b1; bus.A3 = 5'd4; bus.WD3 = 32'h12345678;
    bus.A1 = 5'd4; bus.A2 = 5'd4;
    #1;
    push(Bypass ? 32'h12345678 : 32'h0BAD0BAD); chk("byp_rd1", bus.RD1);
    push(Bypass ? 32'h12345678 : 32'h0BAD0BAD); chk("byp_rd2", bus.RD2);
    push(Bypass ? 32'h0 : 32'h1); chk("byp_busy1", {31'b0, bus.BUSY1});
    push(Bypass ? 32'h0 : 32'h1); chk("byp_busy2", {31'b0, bus.BUSY2});
    nx();
    bus.A1 = 5'd4;
    #1;
    push(32'h12345678); chk("r4_data_after", bus.RD1);
    push(32'h0); chk("r4_busy_after", {31'b0, bus.BUSY1});

    // Untracked write to reg9 must not underflow.
    nx();
    bus.WE3 = 1'b1; bus.A3 = 5'd9; bus.WD3 = 32'h00000099; bus.A1 = 5'd9;
    #1;
    push(32'h0); chk("r9_busy_wr", {31'b0, bus.BUSY1});
    nx();
    bus.A1 = 5'd9; bus.ISSUE_RD = 5'd9;
    #1;
    push(32'h00000099); chk("r9_data", bus.RD1);
    push(32'h0); chk("r9_busy_idle", {31'b0, bus.BUSY1});
    push(32'h0); chk("r9_full_idle", {31'b0, bus.ISSUE_FULL});
    bus.ISSUE_EN = 1'b1;
    nx();
    bus.A1 = 5'd9; bus.ISSUE_RD = 5'd9;
    #1;
    push(32'h1); chk("r9_busy_issued", {31'b0, bus.BUSY1});
    push(32'h0); chk("r9_full_issued", {31'b0, bus.ISSUE_FULL});
    bus.WE3 = 1'b1; bus.A3 = 5'd9; bus.WD3 = 32'h0000009A;
    nx();
    bus.A1 = 5'd9;
    #1;
    push(32'h0); chk("r9_busy_retired", {31'b0, bus.BUSY1});
    push(32'h0000009A); chk("r9_data2", bus.RD1);

    // An untouched register still reads its reset value.
    bus.A2 = 5'd20;
    #1;
    push(32'h0); chk("r20_untouched", bus.RD2);

    if (exp_q.size() != 0) begin
      bad++;
      $error("FAIL leftover_expectations observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
